// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_ADDER_OVF_EN to add the registered signed-overflow output ovf.

module cla_adder_grp #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic [GROUP-1:0] c,
  output logic             gp,
  output logic             gg
);
  // c[i] is the carry into bit i of this group; gp/gg do not depend on cin
  always_comb begin
    c[0] = cin;
    for (int i = 1; i < GROUP; i++) c[i] = g[i-1] | (p[i-1] & c[i-1]);
    gp = &p;
    gg = 1'b0;
    for (int i = 0; i < GROUP; i++) gg = g[i] | (p[i] & gg);
  end
endmodule

module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH < 4) begin : g_bad_cfg
    $error("cla_adder_pipe: WIDTH must be >= 4 and a multiple of GROUP");
  end

  logic             s1_vld;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c0;
  logic             ld1, ld2;
  logic [WIDTH-1:0] bx;
  logic [NG-1:0]    grp_p, grp_g;
  logic [NG:0]      gc;
  logic [WIDTH:0]   c;
  logic             acc;

  assign ld2      = !out_valid || out_ready;
  assign ld1      = !s1_vld || ld2;
  assign in_ready = rst_n && ld1;
  assign bx       = sub ? ~b : b;

  // Stage 1: propagate/generate and carry-in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_p   <= '0;
      s1_g   <= '0;
      s1_c0  <= 1'b0;
    end else if (ld1) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_p  <= a ^ bx;
        s1_g  <= a & bx;
        s1_c0 <= sub | cin;
      end
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_adder_grp #(.GROUP(GROUP)) u_grp (
      .p  (s1_p[k*GROUP +: GROUP]),
      .g  (s1_g[k*GROUP +: GROUP]),
      .cin(gc[k]),
      .c  (c[k*GROUP +: GROUP]),
      .gp (grp_p[k]),
      .gg (grp_g[k])
    );
  end
  assign c[WIDTH] = gc[NG];

  // Each group carry is expanded directly from c0 and the group P/G terms
  always_comb begin
    acc   = 1'b0;
    gc[0] = s1_c0;
    for (int k = 0; k < NG; k++) begin
      acc = s1_c0;
      for (int j = 0; j <= k; j++) acc = grp_g[j] | (grp_p[j] & acc);
      gc[k+1] = acc;
    end
  end

  // Stage 2: sum / carry-out register, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef CLA_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (ld2) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        sum  <= s1_p ^ c[WIDTH-1:0];
        cout <= c[WIDTH];
`ifdef CLA_ADDER_OVF_EN
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: directed corner cases, stall, reset, random traffic.
// Honours CLA_ADDER_OVF_EN for the optional ovf output.

module tb_cla_adder_pipe;
  localparam int W = 16;
  localparam int G = 4;

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] sum;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, in_valid, in_ready, cout, out_valid, out_ready;
  logic         dut_ovf;
  res_t         cur;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(W), .GROUP(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .cout     (cout),
`ifdef CLA_ADDER_OVF_EN
    .ovf      (dut_ovf),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

`ifndef CLA_ADDER_OVF_EN
  assign dut_ovf = 1'b0;
`endif
  assign cur = {dut_ovf, cout, sum};

  res_t sb[$];
  int   checks = 0, errors = 0, acc_cnt = 0, out_cnt = 0;

  // Reference: plain integer arithmetic on the operands
  function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xc, input logic xs);
    res_t         r;
    logic [W:0]   full;
    logic         ov;
    if (xs) begin
      r.sum  = xa - xb;
      r.cout = (xa >= xb);
      ov     = (xa[W-1] != xb[W-1]) && (r.sum[W-1] != xa[W-1]);
    end else begin
      full   = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      ov     = (xa[W-1] == xb[W-1]) && (r.sum[W-1] != xa[W-1]);
    end
`ifdef CLA_ADDER_OVF_EN
    r.ovf = ov;
`else
    r.ovf = 1'b0 & ov;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares on every output transfer, checks hold under stall
  res_t held;
  bit   stalled = 1'b0;
  always @(negedge clk) begin
    res_t e;
    #3;
    if (!rst_n) stalled = 1'b0;
    else begin
      if (stalled) chk("stall_hold", {out_valid, cur}, {1'b1, held});
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%h required=none at %0t", cur, $time);
        end else begin
          e = sb.pop_front();
          chk("result", cur, e);
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = cur;
      end else stalled = 1'b0;
    end
  end

  task automatic tick(output bit acc);
    @(negedge clk);
    #3;
    acc = in_valid && in_ready;
    if (acc) begin
      sb.push_back(model(a, b, cin, sub));
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc, input logic xs, output bit acc);
    in_valid = 1'b1;
    a = xa; b = xb; cin = xc; sub = xs;
    tick(acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int lat, n;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Full ripple carry and latency
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
    chk("accept_ripple", acc, 1);
    in_valid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid || lat > 10) break;
      @(posedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
    #1;
    chk("latency", lat, 2);
    idle(2);

    // Subtraction, overflow, cin handling, back to back
    send(16'h1234, 16'h1235, 1'b0, 1'b1, acc);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, acc);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, acc);
    send(16'h0005, 16'h0005, 1'b1, 1'b1, acc);
    send(16'h0000, 16'h0001, 1'b1, 1'b1, acc);
    idle(4);

    // Stall: two accepts then in_ready drops
    out_ready = 1'b0;
    send(16'h0011, 16'h0022, 1'b0, 1'b0, acc);
    chk("stall_acc1", acc, 1);
    send(16'h0100, 16'h0200, 1'b1, 1'b0, acc);
    chk("stall_acc2", acc, 1);
    send(16'h3000, 16'h0003, 1'b0, 1'b1, acc);
    chk("stall_acc3_blocked", acc, 0);
    chk("stall_in_ready", in_ready, 0);
    repeat (3) begin
      tick(acc);
      chk("stall_still_blocked", acc, 0);
    end
    out_ready = 1'b1;
    tick(acc);
    chk("stall_release_acc3", acc, 1);
    idle(4);

    // Reset with two operations in flight
    out_ready = 1'b0;
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0, acc);
    send(16'h1111, 16'h2222, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_in_ready", in_ready, 0);
    sb.delete();
    acc_cnt = 0;
    out_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midrst_in_ready_rise", in_ready, 1);
    idle(3);
    chk("no_stale_out", out_valid, 0);

    // Random traffic
    n = 0;
    while (acc_cnt < 10000 && n < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        2: b = a;
        default: ;
      endcase
      tick(acc);
      n++;
    end
    chk("random_accepts", acc_cnt, 10000);
    out_ready = 1'b1;
    idle(5);
    chk("drain_empty", sb.size(), 0);
    chk("out_count", out_cnt, acc_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_adder_pipe.md
CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width; SHALL be a multiple of GROUP and at least 4.
REQ-002 Parameter GROUP, default 4: carry-lookahead group size in bits.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port a  input  WIDTH  operand A.
REQ-006 Port b  input  WIDTH  operand B.
REQ-007 Port cin  input  1  carry-in; ignored when sub=1.
REQ-008 Port sub  input  1  mode select: 0 = add, 1 = subtract (A-B).
REQ-009 Port in_valid  input  1  operands valid.
REQ-010 Port in_ready  output  1  block accepts operands this cycle.
REQ-011 Port sum  output  WIDTH  result.
REQ-012 Port cout  output  1  carry-out of the MSB; for sub=1, 1 means no borrow.
REQ-013 Port out_valid  output  1  sum/cout valid.
REQ-014 Port out_ready  input  1  downstream accepts the result.

Function
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-016 Stage 1 SHALL register p = a ^ b', g = a & b' and c0, where b' = sub ? ~b : b and c0 = sub ? 1 : cin.
REQ-017 Stage 2 SHALL compute group P/G per GROUP bits, inter-group carries by lookahead, and bit carries c[i]; it SHALL register sum[i] = p[i] ^ c[i] and cout = c[WIDTH].
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready stays high; throughput SHALL be one operation per cycle.
REQ-019 Stage 2 SHALL load when !out_valid || out_ready; stage 1 SHALL load when it is empty or stage 2 loads; in_ready SHALL equal the stage 1 load condition (combinational from out_ready).
REQ-020 While out_valid && !out_ready, sum, cout and out_valid SHALL hold; no result SHALL be dropped or duplicated.
REQ-021 With both stages full and out_ready low, in_ready SHALL be 0.
REQ-022 Input transfer and output transfer in the same cycle SHALL both complete.
REQ-023 Results SHALL be modulo 2^WIDTH; carry beyond WIDTH appears only on cout.
REQ-024 Results SHALL leave in input order.

Reset
REQ-025 On rst_n low, both stage valid flags, out_valid, sum, cout and all pipeline registers SHALL clear to 0 immediately; while rst_n is low, in_ready SHALL be 0.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; the first transfer after release SHALL produce the first output.
REQ-027 in_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-028 With macro CLA_ADDER_OVF_EN defined, an output ovf (1 bit) SHALL be present, registered with sum and equal to c[WIDTH] ^ c[WIDTH-1] (signed overflow); it SHALL reset to 0 and hold under stall.
REQ-029 Without CLA_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=16, GROUP=4)
REQ-030 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> two cycles later out_valid=1, sum=0x0000, cout=1 (full carry ripple across all groups).
REQ-031 a=0x1234, b=0x1235, sub=1 -> sum=0xFFFF, cout=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1 when CLA_ADDER_OVF_EN is defined.
REQ-032 Three back-to-back operations with out_ready held 0 -> in_ready falls after two accepts; third held; raising out_ready releases results 1, 2, 3 in order, each held stable while stalled.
REQ-033 rst_n pulsed low with two operations in flight -> out_valid=0 and sum=0 immediately; no stale result after release.
REQ-034 Random 10,000 operands with random in_valid/out_ready -> every result equals the {cout,sum} reference model; count of outputs equals count of accepted inputs.
